// File: rtl/cmd_bus_checker_pkg.sv
// cmd_bus_pkg
// Shared types and constants for the DDR2 command bus checker:
//   cmd_e       - command encodings seen on the bus
//   err_code_e  - reported error codes (1 = lowest priority number, reported first)
//   state_e     - burst tracking states
//   E_*         - bit positions of each error in the per-cycle error vector
//   lowest_code - maps an error vector to the code that err_code reports
package cmd_bus_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    SCR  = 3'd1,
    SCW  = 3'd2,
    BLR  = 3'd3,
    BLW  = 3'd4,
    ATR  = 3'd5,
    ATW  = 3'd6,
    NOP7 = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ERR_NONE    = 4'd0,
    ERR_CMD_X   = 4'd1,
    ERR_ADDR_X  = 4'd2,
    ERR_CTRL_X  = 4'd3,
    ERR_DIN_X   = 4'd4,
    ERR_RANGE   = 4'd5,
    ERR_ALIGN   = 4'd6,
    ERR_OP_ILL  = 4'd7,
    ERR_OVERLAP = 4'd8,
    ERR_HANG    = 4'd9
  } err_code_e;

  typedef enum logic {
    IDLE     = 1'b0,
    BLW_DATA = 1'b1
  } state_e;

  localparam int BURST_UNIT = 8;
  localparam int NUM_ERR    = 9;

  // error vector bit = error code - 1
  localparam int E_CMD_X   = 0;
  localparam int E_ADDR_X  = 1;
  localparam int E_CTRL_X  = 2;
  localparam int E_DIN_X   = 3;
  localparam int E_RANGE   = 4;
  localparam int E_ALIGN   = 5;
  localparam int E_OP_ILL  = 6;
  localparam int E_OVERLAP = 7;
  localparam int E_HANG    = 8;

  function automatic logic [3:0] lowest_code(input logic [NUM_ERR-1:0] vec);
    logic [3:0] code;
    code = 4'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (vec[i]) code = 4'(i + 1);
    end
    return code;
  endfunction

endpackage

// File: rtl/cmd_bus_checker_err_log.sv
// cmd_bus_err_log
// Error reporting registers fed by the checker's per-cycle error vector.
// Ports:
//   clk, reset            - clock, async active-high reset
//   err_clr               - clears sticky, counters and first-error capture
//   err_vec[8:0]          - errors detected this sample (bit = code-1)
//   accept                - a command was accepted this sample
//   addr                  - bus address of this sample (for first-error capture)
//   err_valid / err_code  - one-cycle pulse and lowest code of the previous sample
//   err_sticky            - accumulated error bits
//   err_first_code/_addr  - first error since reset or clear
//   err_count, cmd_count  - saturating error-cycle and accepted-command counts
module cmd_bus_err_log
  import cmd_bus_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               err_clr,
  input  logic [NUM_ERR-1:0] err_vec,
  input  logic               accept,
  input  logic [ADDR_W-1:0]  addr,
  output logic               err_valid,
  output logic [3:0]         err_code,
  output logic [NUM_ERR-1:0] err_sticky,
  output logic [3:0]         err_first_code,
  output logic [ADDR_W-1:0]  err_first_addr,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   cmd_count
);

  logic       any_err;
  logic [3:0] code_now;

  assign any_err  = |err_vec;
  assign code_now = lowest_code(err_vec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid      <= 1'b0;
      err_code       <= 4'd0;
      err_sticky     <= '0;
      err_first_code <= 4'd0;
      err_first_addr <= '0;
      err_count      <= '0;
      cmd_count      <= '0;
    end else begin
      err_valid <= any_err;
      err_code  <= code_now;
      if (err_clr) begin
        // a coincident error or accept is the first event after the clear
        err_sticky     <= err_vec;
        err_count      <= CNT_W'(any_err);
        cmd_count      <= CNT_W'(accept);
        err_first_code <= code_now;
        err_first_addr <= any_err ? addr : '0;
      end else begin
        err_sticky <= err_sticky | err_vec;
        if (any_err && (err_count != '1)) err_count <= err_count + CNT_W'(1);
        if (accept && (cmd_count != '1)) cmd_count <= cmd_count + CNT_W'(1);
        if (any_err && (err_first_code == 4'd0)) begin
          err_first_code <= code_now;
          err_first_addr <= addr;
        end
      end
    end
  end

endmodule

// File: rtl/cmd_bus_checker.sv
// cmd_bus_checker
// Passive protocol checker for the DDR2 controller command bus. Checks
// encodings, X-propagation, address range/alignment, block-write data
// bursts and hung commands; reports via cmd_bus_err_log. Drives nothing
// back onto the bus.
// Ports:
//   clk, reset                    - clock, async active-high reset
//   cmd, sz, op, fetching, din,
//   addr                          - observed bus signals
//   err_clr                       - sync clear of sticky/count/capture
//   err_valid, err_code, err_sticky, err_first_code, err_first_addr,
//   err_count, cmd_count          - error reporting (latency 1)
//   burst_active                  - block-write data burst in progress
// Optional: define CMD_BUS_CHECKER_SVA_EN to also compile one concurrent
// assertion per rule.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | watching for commands; BLW accept starts a data burst
// BLW_DATA | counting write beats; any command here is an overlap
module cmd_bus_checker
  import cmd_bus_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int BANK_LSB = 3,
  parameter int ROW_LSB  = 12,
  parameter int COL_W    = 10,
  parameter int ROW_MAX  = 8191,
  parameter int COL_MAX  = 1023,
  parameter int OP_MAX   = 7,
  parameter int HANG_CYC = 64,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         cmd,
  input  logic [1:0]         sz,
  input  logic [2:0]         op,
  input  logic               fetching,
  input  logic [DATA_W-1:0]  din,
  input  logic [ADDR_W-1:0]  addr,
  input  logic               err_clr,
  output logic               err_valid,
  output logic [3:0]         err_code,
  output logic [NUM_ERR-1:0] err_sticky,
  output logic [3:0]         err_first_code,
  output logic [ADDR_W-1:0]  err_first_addr,
  output logic [CNT_W-1:0]   err_count,
  output logic [CNT_W-1:0]   cmd_count,
  output logic               burst_active
);

  localparam int HW = $clog2(HANG_CYC + 1);
  localparam logic [HW-1:0]    HANG_LAST = HW'(HANG_CYC - 1);
  localparam logic [HW-1:0]    HANG_TOP  = HW'(HANG_CYC);
  localparam logic [12:0]      ROW_MAX_V = 13'(ROW_MAX);
  localparam logic [COL_W-1:0] COL_MAX_V = COL_W'(COL_MAX);
  localparam logic [2:0]       OP_MAX_V  = 3'(OP_MAX);

  state_e       state;
  logic [4:0]   beats_left;
  logic [HW-1:0] hang_cnt;
  logic [2:0]   cmd_q;

  cmd_e         cmd_v;
  logic         cmd_x, addr_x, sz_x, op_x, din_x;
  logic         is_idle, non_nop, is_blk, is_atom, uses_sz, writes_din, accept;
  logic [12:0]  row;
  logic [COL_W-1:0] col;
  logic         hang_hold, hang_fire;
  logic [HW-1:0] hang_base, hang_next;
  logic [NUM_ERR-1:0] err_vec;

  // the bank field feeds no rule; it is decoded only for reference
  logic [1:0]   unused_bank;
  assign unused_bank = addr[BANK_LSB +: 2];

  assign cmd_v   = cmd_e'(cmd);
  assign cmd_x   = $isunknown(cmd);
  assign addr_x  = $isunknown(addr);
  assign sz_x    = $isunknown(sz);
  assign op_x    = $isunknown(op);
  assign din_x   = $isunknown(din);
  assign row     = addr[ROW_LSB +: 13];
  assign col     = addr[COL_W-1:0];
  assign is_idle = (state == IDLE);

  always_comb begin
    non_nop    = !cmd_x && (cmd_v != NOP) && (cmd_v != NOP7);
    is_blk     = non_nop && (cmd_v inside {BLR, BLW});
    is_atom    = non_nop && (cmd_v inside {ATR, ATW});
    uses_sz    = non_nop && (cmd_v inside {BLR, BLW, ATR, ATW});
    writes_din = non_nop && (cmd_v inside {SCW, BLW, ATR, ATW});
    accept     = is_idle && non_nop && fetching;
  end

  // Hang run length: consecutive cycles of the same command held without
  // fetching. A zero count means no run is in progress, so cmd_q is only
  // consulted while one is.
  always_comb begin
    hang_hold = is_idle && non_nop && !fetching;
    hang_base = ((hang_cnt != '0) && (cmd == cmd_q)) ? hang_cnt : '0;
    hang_fire = hang_hold && (hang_base == HANG_LAST);
    hang_next = '0;
    if (hang_hold) hang_next = (hang_base == HANG_TOP) ? HANG_TOP : hang_base + HW'(1);
  end

  always_comb begin
    err_vec            = '0;
    err_vec[E_CMD_X]   = is_idle && cmd_x;
    err_vec[E_ADDR_X]  = is_idle && non_nop && addr_x;
    err_vec[E_CTRL_X]  = is_idle && ((uses_sz && sz_x) || (is_atom && op_x));
    err_vec[E_DIN_X]   = din_x && ((accept && writes_din) || (!is_idle && fetching));
    err_vec[E_RANGE]   = is_idle && non_nop && !addr_x && ((row > ROW_MAX_V) || (col > COL_MAX_V));
    err_vec[E_ALIGN]   = is_idle && is_blk && !addr_x && (addr[2:0] != 3'b000);
    err_vec[E_OP_ILL]  = is_idle && is_atom && !op_x && (op > OP_MAX_V);
    err_vec[E_OVERLAP] = !is_idle && non_nop;
    err_vec[E_HANG]    = hang_fire;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      beats_left   <= 5'd0;
      hang_cnt     <= '0;
      cmd_q        <= 3'd0;
      burst_active <= 1'b0;
    end else begin
      cmd_q    <= cmd;
      hang_cnt <= hang_next;
      case (state)
        IDLE: begin
          if (accept && (cmd_v == BLW)) begin
            // accept cycle carries beat 0
            beats_left   <= 5'((int'(sz) + 1) * BURST_UNIT - 1);
            state        <= BLW_DATA;
            burst_active <= 1'b1;
          end
        end
        BLW_DATA: begin
          if (fetching) begin
            if (beats_left <= 5'd1) begin
              beats_left   <= 5'd0;
              state        <= IDLE;
              burst_active <= 1'b0;
            end else begin
              beats_left <= beats_left - 5'd1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          burst_active <= 1'b0;
        end
      endcase
    end
  end

  cmd_bus_err_log #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_err_log (
    .clk            (clk),
    .reset          (reset),
    .err_clr        (err_clr),
    .err_vec        (err_vec),
    .accept         (accept),
    .addr           (addr),
    .err_valid      (err_valid),
    .err_code       (err_code),
    .err_sticky     (err_sticky),
    .err_first_code (err_first_code),
    .err_first_addr (err_first_addr),
    .err_count      (err_count),
    .cmd_count      (cmd_count)
  );

`ifdef CMD_BUS_CHECKER_SVA_EN
  for (genvar g = 0; g < NUM_ERR; g++) begin : g_rule
    a_rule : assert property (@(posedge clk) disable iff (reset) !err_vec[g])
      else $error("cmd_bus_checker: error code %0d cmd=%0d addr=%h",
                  g + 1, $sampled(cmd), $sampled(addr));
  end
`else
  // rules are reported through the registered outputs only
`endif

endmodule

// File: tb/tb_cmd_bus_checker.sv
module tb_cmd_bus_checker;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;
  localparam int HANG   = 64;
  localparam int ROWMAX = 4095;
  localparam int COLMAX = 1000;
  localparam int OPMAX  = 5;
  localparam int CMAX   = 255;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] cmd, op;
  logic [1:0] sz;
  logic fetching, err_clr;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addr;
  logic err_valid, burst_active;
  logic [3:0] err_code, err_first_code;
  logic [8:0] err_sticky;
  logic [ADDR_W-1:0] err_first_addr;
  logic [CNT_W-1:0] err_count, cmd_count;

  cmd_bus_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_MAX(ROWMAX), .COL_MAX(COLMAX),
    .OP_MAX(OPMAX), .HANG_CYC(HANG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .sz(sz), .op(op), .fetching(fetching),
    .din(din), .addr(addr), .err_clr(err_clr), .err_valid(err_valid),
    .err_code(err_code), .err_sticky(err_sticky), .err_first_code(err_first_code),
    .err_first_addr(err_first_addr), .err_count(err_count), .cmd_count(cmd_count),
    .burst_active(burst_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit          m_valid;
  int          m_code;
  logic [8:0]  m_sticky;
  int          m_first_code;
  logic [ADDR_W-1:0] m_first_addr;
  int          m_err_cnt, m_cmd_cnt;
  bit          m_burst;
  int          m_left;
  int          m_run, m_run_cmd;

  task automatic model_reset();
    m_valid = 0; m_code = 0; m_sticky = '0; m_first_code = 0; m_first_addr = '0;
    m_err_cnt = 0; m_cmd_cnt = 0; m_burst = 0; m_left = 0; m_run = 0; m_run_cmd = 0;
  endtask

  task automatic model_step();
    logic [8:0] e;
    bit idle, cx, ax, nonnop, acc, any;
    int c, a, row, col, code;
    if (reset) begin
      model_reset();
      return;
    end
    e = '0;
    idle = !m_burst;
    cx = $isunknown(cmd);
    ax = $isunknown(addr);
    c = cx ? -1 : int'(cmd);
    a = ax ? 0 : int'(addr);
    row = a / 4096;
    col = a % 1024;
    nonnop = (c >= 1) && (c <= 6);
    acc = idle && nonnop && fetching;
    if (idle) begin
      if (cx) e[0] = 1;
      if (nonnop) begin
        if (ax) e[1] = 1;
        if ((c >= 3 && $isunknown(sz)) || (c >= 5 && $isunknown(op))) e[2] = 1;
        if (acc && (c == 2 || c >= 4) && $isunknown(din)) e[3] = 1;
        if (!ax && (row > ROWMAX || col > COLMAX)) e[4] = 1;
        if ((c == 3 || c == 4) && !ax && (a % 8 != 0)) e[5] = 1;
        if (c >= 5 && !$isunknown(op) && int'(op) > OPMAX) e[6] = 1;
      end
      if (nonnop && !fetching) begin
        m_run = (m_run > 0 && c == m_run_cmd) ? m_run + 1 : 1;
        m_run_cmd = c;
        if (m_run == HANG) e[8] = 1;
      end else begin
        m_run = 0;
      end
      if (acc && c == 4) begin
        m_burst = 1;
        m_left = 8 * (int'(sz) + 1) - 1;
      end
    end else begin
      if (fetching && $isunknown(din)) e[3] = 1;
      if (nonnop) e[7] = 1;
      m_run = 0;
      if (fetching) begin
        m_left--;
        if (m_left == 0) m_burst = 0;
      end
    end
    any = (e != 0);
    code = 0;
    for (int i = 0; i < 9; i++) if (e[i] && code == 0) code = i + 1;
    m_valid = any;
    m_code = code;
    if (err_clr) begin
      m_sticky = e;
      m_err_cnt = any ? 1 : 0;
      m_cmd_cnt = acc ? 1 : 0;
      m_first_code = code;
      m_first_addr = any ? addr : '0;
    end else begin
      m_sticky = m_sticky | e;
      if (any && m_err_cnt < CMAX) m_err_cnt++;
      if (acc && m_cmd_cnt < CMAX) m_cmd_cnt++;
      if (any && m_first_code == 0) begin
        m_first_code = code;
        m_first_addr = addr;
      end
    end
  endtask

  task automatic compare_all();
    chk("err_valid", 32'(err_valid), 32'(m_valid));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("err_first_code", 32'(err_first_code), 32'(m_first_code));
    chk("err_first_addr", 32'(err_first_addr), 32'(m_first_addr));
    chk("err_count", 32'(err_count), 32'(m_err_cnt));
    chk("cmd_count", 32'(cmd_count), 32'(m_cmd_cnt));
    chk("burst_active", 32'(burst_active), 32'(m_burst));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] s, input logic [2:0] o,
                       input logic f, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic clr);
    cmd = c; sz = s; op = o; fetching = f; addr = a; din = d; err_clr = clr;
  endtask

  typedef struct {
    logic [2:0]        cmd;
    logic [2:0]        op;
    logic              fetching;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        exp_code;
  } vec_t;

  vec_t tbl[14];

  int cnt, idx, chg, fprob;

  initial begin
    tbl[0]  = '{3'd3, 3'd0, 1'b1, 25'h0001008, 4'd0};
    tbl[1]  = '{3'd1, 3'd0, 1'b1, 25'h0000010, 4'd0};
    tbl[2]  = '{3'd3, 3'd0, 1'b1, 25'h0000003, 4'd6};
    tbl[3]  = '{3'd5, 3'd6, 1'b1, 25'h0000000, 4'd7};
    tbl[4]  = '{3'd6, 3'd5, 1'b1, 25'h0000005, 4'd0};
    tbl[5]  = '{3'd2, 3'd0, 1'b1, 25'h1388000, 4'd5};
    tbl[6]  = '{3'd1, 3'd0, 1'b1, 25'h00003E9, 4'd5};
    tbl[7]  = '{3'd5, 3'd7, 1'b0, 25'h0000005, 4'd7};
    tbl[8]  = '{3'd3, 3'd0, 1'b1, 25'h1388001, 4'd5};
    tbl[9]  = '{3'd7, 3'd0, 1'b1, 25'h1388000, 4'd0};
    tbl[10] = '{3'd0, 3'd0, 1'b0, 25'h1388003, 4'd0};
    tbl[11] = '{3'd2, 3'd0, 1'b0, 25'h00003FF, 4'd5};
    tbl[12] = '{3'd6, 3'd7, 1'b1, 25'h1388000, 4'd5};
    tbl[13] = '{3'd3, 3'd0, 1'b0, 25'h0FFF000, 4'd0};

    reset = 1'b1;
    drive(3'd0, 2'd0, 3'd0, 1'b0, '0, '0, 1'b0);
    model_reset();
    step();
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_burst", 32'(burst_active), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count), 32'd0);
    reset = 1'b0;
    step();

    // single-cycle vectors from IDLE
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].cmd, 2'd0, tbl[i].op, tbl[i].fetching, tbl[i].addr, 16'h1234, 1'b0);
      step();
      chk("tbl_code", 32'(err_code), 32'(tbl[i].exp_code));
      chk("tbl_valid", 32'(err_valid), 32'(tbl[i].exp_code != 0));
      if (i == 0) chk("blr_cmd_count", 32'(cmd_count), 32'd1);
    end

    // BLW sz=1: 16 beats, burst_active for 15 cycles
    drive(3'd0, 2'd0, 3'd0, 1'b0, '0, '0, 1'b1);
    step();
    drive(3'd4, 2'd1, 3'd0, 1'b1, 25'h0000040, 16'hA5A5, 1'b0);
    step();
    cnt = 32'(burst_active);
    for (int i = 0; i < 15; i++) begin
      drive(3'd0, 2'd0, 3'd0, 1'b1, '0, 16'(i), 1'b0);
      step();
      if (burst_active) cnt++;
    end
    chk("blw_active_cycles", 32'(cnt), 32'd15);
    chk("blw_no_err", 32'(err_sticky), 32'd0);

    // SCR during beat 4 of a sz=0 burst
    drive(3'd4, 2'd0, 3'd0, 1'b1, 25'h0000080, 16'h0, 1'b0);
    step();
    for (int b = 1; b <= 7; b++) begin
      drive((b == 4) ? 3'd1 : 3'd0, 2'd0, 3'd0, 1'b1, 25'h0000090, 16'(b), 1'b0);
      step();
      if (b == 4) begin
        chk("overlap_code", 32'(err_code), 32'd8);
        chk("overlap_sticky", 32'(err_sticky[7]), 32'd1);
      end
    end
    chk("sz0_burst_done", 32'(burst_active), 32'd0);

    // clear coinciding with an error: error wins
    drive(3'd3, 2'd0, 3'd0, 1'b1, 25'h0000003, 16'h0, 1'b1);
    step();
    chk("clr_err_count", 32'(err_count), 32'd1);
    chk("clr_first_code", 32'(err_first_code), 32'd6);
    chk("clr_sticky", 32'(err_sticky), 32'h020);

    // X on control/data (observable only in a four-state simulator)
    drive(3'd5, 2'd0, 3'bxx1, 1'b1, 25'h0000003, 16'h0, 1'b1);
    step();
    drive(3'd2, 2'd0, 3'd0, 1'b1, 25'h0001234, 'x, 1'b0);
    step();

    // hang: SCR held without fetching
    drive(3'd0, 2'd0, 3'd0, 1'b0, '0, '0, 1'b1);
    step();
    cnt = 0; idx = -1;
    for (int i = 1; i <= 70; i++) begin
      drive(3'd1, 2'd0, 3'd0, 1'b0, 25'h0000100, 16'h0, 1'b0);
      step();
      if (err_valid && err_code == 4'd9) begin
        cnt++;
        idx = i;
      end
    end
    chk("hang_pulses", 32'(cnt), 32'd1);
    chk("hang_cycle", 32'(idx), 32'd64);

    // reset mid-burst
    drive(3'd4, 2'd3, 3'd0, 1'b1, 25'h0000200, 16'h0, 1'b0);
    step();
    drive(3'd0, 2'd0, 3'd0, 1'b1, '0, '0, 1'b0);
    step();
    step();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_burst", 32'(burst_active), 32'd0);
    chk("rst_mid_sticky", 32'(err_sticky), 32'd0);
    chk("rst_mid_count", 32'(cmd_count), 32'd0);
    chk("rst_mid_first", 32'(err_first_addr), 32'd0);
    step();
    reset = 1'b0;
    step();

    // randomized traffic: busy bus, then a stalled bus
    for (int ph = 0; ph < 2; ph++) begin
      chg   = (ph == 0) ? 30 : 2;
      fprob = (ph == 0) ? 70 : 3;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 99) < chg) cmd = 3'($urandom_range(0, 7));
        sz = 2'($urandom_range(0, 3));
        op = ($urandom_range(0, 15) == 0) ? 3'bxx1 : 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0)
          addr = 25'($urandom_range(0, 4095) * 4096 + $urandom_range(0, 120) * 8);
        else
          addr = 25'($urandom());
        din = ($urandom_range(0, 19) == 0) ? 'x : 16'($urandom());
        fetching = ($urandom_range(0, 99) < fprob);
        err_clr = ($urandom_range(0, 599) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_bus_checker.md
# cmd_bus_checker

Parametrised, cycle-accurate protocol checker for the command bus between the controller driver and the DDR2 controller. It watches the bus and validates encodings, X-propagation, address ranges and alignment. It also tracks block-write data bursts and watches for hung commands. Results are reported as registered error pulses, sticky flags, a first-error capture and saturating counters. It is a passive, bind-able observer and drives nothing back onto the bus.

## Interface
Parameters:
- ADDR_W, 25, address width
- DATA_W, 16, din width
- BANK_LSB, 3, LSB of the 2-bit bank field
- ROW_LSB, 12, LSB of the 13-bit row field
- COL_W, 10, column field width, at addr[COL_W-1:0]
- ROW_MAX, 8191, highest legal row
- COL_MAX, 1023, highest legal column
- OP_MAX, 7, highest legal atomic op
- HANG_CYC, 64, cycles a non-NOP command may wait for fetching
- CNT_W, 16, counter width

Ports:
- clk  in  1  system clock; everything samples on rising edge
- reset  in  1  asynchronous, active-high
- cmd  in  3  command (0/7 NOP, 1 SCR, 2 SCW, 3 BLR, 4 BLW, 5 ATR, 6 ATW)
- sz  in  2  block size
- op  in  3  atomic op
- fetching  in  1  controller accepting command/data this cycle
- din  in  DATA_W  write data
- addr  in  ADDR_W  address
- err_clr  in  1  synchronous clear of sticky/count/capture
- err_valid  out  1  one-cycle pulse, error detected on the previous sample
- err_code  out  4  highest-priority error code of that sample
- err_sticky  out  9  bit (code-1) set per error ever seen
- err_first_code  out  4  code of the first error since reset/clear
- err_first_addr  out  ADDR_W  addr at the first error
- err_count  out  CNT_W  error cycles, saturating
- cmd_count  out  CNT_W  accepted commands, saturating
- burst_active  out  1  FSM in BLW_DATA

## Operation
- Accept: cmd ∉ {0,7}, cmd known, fetching=1, FSM in IDLE.
- Error codes, with priority lowest first:
  - 1 CMD_X: cmd has X/Z while in IDLE.
  - 2 ADDR_X: addr has X/Z on a non-NOP cmd.
  - 3 CTRL_X: sz X for cmd 3–6, or op X for cmd 5–6.
  - 4 DIN_X: din X on accept of cmd 2, 4, 5 or 6.
  - 5 RANGE: row > ROW_MAX or col > COL_MAX on a non-NOP cmd.
  - 6 ALIGN: cmd 3/4 with addr[2:0] ≠ 0.
  - 7 OP_ILL: cmd 5/6 with op > OP_MAX.
  - 8 OVERLAP: known non-NOP cmd while in BLW_DATA.
  - 9 HANG: same non-NOP cmd held HANG_CYC consecutive cycles with fetching=0.
- Code 4 is also raised for a din X on any beat in BLW_DATA.
- FSM states:
  - IDLE: accepting BLW loads beats_left = 8·(sz+1) − 1 and moves to BLW_DATA.
  - BLW_DATA: each fetching=1 cycle is one beat and decrements beats_left. When the last beat is taken, return to IDLE. cmd is ignored except for OVERLAP.
- Beat counter width: 5 bits (max 31).
- Hang counter: reset to 0 on accept, on cmd change or on NOP. Saturates at HANG_CYC. HANG fires once per held command.
- Multiple errors in one sample: all their sticky bits set; err_code shows the lowest code; err_count increments by 1.
- First-error capture loads only while err_first_code == 0.
- err_clr clears sticky bits, counts and capture. It does not affect FSM or hang state. If err_clr coincides with an error, the error wins: the flags are reloaded from that error.

## Timing
- All checks sample at edge N; the outputs of that sample are valid after edge N+1 (latency 1).
- Reset values: every output 0; FSM IDLE; beats_left 0; hang counter 0.
- Reset mid-burst aborts the burst immediately with no error.
- The BLW accept cycle carries beat 0. A burst with sz=0 completes after 7 further fetching=1 cycles; burst_active falls the cycle after the last beat.
- Counters hold at all-ones.

## Configuration
- CMD_BUS_CHECKER_SVA_EN defined: each rule also becomes a concurrent assertion, disable iff (reset), which reports $error with code, cmd and addr.
- Undefined: only the registered outputs above; no assertions are compiled.

## Structure
- Package cmd_bus_pkg holds:
  - the cmd_e enum (NOP, SCR, SCW, BLR, BLW, ATR, ATW, NOP7);
  - the err_code_e enum (codes 1–9);
  - the state_e enum (IDLE, BLW_DATA);
  - the BURST_UNIT=8 constant.
- One sub-module, cmd_bus_err_log, holds the sticky, count and first-capture registers. It is fed by a per-cycle error vector.

## Test plan
- BLR at addr 25'h0001008 (bank 1, col 8), fetching=1 → no error, cmd_count=1.
- BLW with sz=1, then 15 beats with fetching=1 → burst_active high for 15 cycles, no error.
- SCR issued on beat 4 of a BLW burst → err_code=8, err_sticky[7]=1 one cycle later.
- din=16'hxxxx on the accept of an SCW → err_code=4, err_first_addr equals that addr.
- ATR with op=3'bxx1 and addr[2:0]=3 → err_code=3, sticky bits 2 set, err_count +1; with ROW_MAX=4095, addr row 5000 → code 5.
- SCR held with fetching=0 for 64 cycles → a single err_code=9 pulse. Assert reset mid-burst → all outputs 0, burst_active 0.
